// File: rtl/sdram_responder.sv
// Purpose : behavioural SDRAM device model with init FSM, per-bank row tracking and protocol checking.
// Latency : read data appears on dq_out for one cycle, CL (2 or 3) cycles after the READ command cycle.
// Backpr. : none; the device samples every command, and any flagged command is dropped with a sticky err bit.
module sdram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int TRCD     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic        ldqm,
    input  logic        udqm,
    input  logic [1:0]  ba,
    input  logic [12:0] addr,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        init_done,
    output logic [5:0]  err,
    output logic [15:0] ref_cnt
);

    localparam int AGE_W = (TRCD < 1) ? 1 : $clog2(TRCD + 1);
    localparam int AW    = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TRCD);

    typedef enum logic [1:0] {
        S_INIT_PRE,
        S_INIT_REF,
        S_INIT_MRS,
        S_READY
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF,
        CMD_MRS,
        CMD_BST
    } cmd_t;

    // Storage (memory is deliberately not reset)
    logic [15:0]         r_mem [0:DEPTH-1];

    // Control state
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_init_ref;
    logic [2:0]          r_cl;
    logic [3:0]          r_open;
    logic [ROW_BITS-1:0] r_row [0:3];
    logic [AGE_W-1:0]    r_age [0:3];
    logic [5:0]          r_err;
    logic [15:0]         r_ref_cnt;

    // Read pipeline: slot 0 drives the pins, a READ enters at slot CL-1
    logic [2:0]          r_pv;
    logic [15:0]         r_pd [0:2];

    // Decode and legality
    cmd_t                w_cmd;
    logic                w_ready;
    logic                w_init_done;
    logic                w_bank_open;
    logic                w_age_ok;
    logic                w_rw;
    logic                w_mrs_ok;
    logic                w_act_ok;
    logic                w_rw_ok;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_ref_ok;
    logic                w_mrs_acc;
    logic [5:0]          w_err_set;
    logic [AW-1:0]       w_idx;
    logic [15:0]         w_rd_word;
    logic [15:0]         w_rd_dat;
    logic [1:0]          w_slot;
    logic                w_unused;

    // Command decode: only a selected, clock-enabled cycle carries a command
    always_comb begin
        w_cmd = CMD_NOP;
        if (cke && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  w_cmd = CMD_ACT;
                3'b101:  w_cmd = CMD_RD;
                3'b100:  w_cmd = CMD_WR;
                3'b010:  w_cmd = CMD_PRE;
                3'b001:  w_cmd = CMD_REF;
                3'b000:  w_cmd = CMD_MRS;
                3'b110:  w_cmd = CMD_BST;
                default: w_cmd = CMD_NOP;
            endcase
        end
    end

    assign w_ready     = (r_state == S_READY);
    assign w_bank_open = r_open[ba];
    // Age counts cycles elapsed since ACTIVE minus one, so a READ one cycle
    // after ACTIVE satisfies TRCD=1.
    assign w_age_ok    = (int'(r_age[ba]) + 1 >= TRCD);
    assign w_rw        = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
    assign w_mrs_ok    = ((addr[6:4] == 3'b010) || (addr[6:4] == 3'b011)) && (addr[2:0] == 3'b000);

    assign w_act_ok  = !rst && (w_cmd == CMD_ACT) && w_ready && !w_bank_open;
    assign w_rw_ok   = !rst && w_rw && w_ready && w_bank_open && w_age_ok
                       && !((w_cmd == CMD_WR) && r_pv[0]);
    assign w_rd_ok   = w_rw_ok && (w_cmd == CMD_RD);
    assign w_wr_ok   = w_rw_ok && (w_cmd == CMD_WR);
    assign w_ref_ok  = !rst && (w_cmd == CMD_REF) && !(w_ready && (|r_open));
    assign w_mrs_acc = !rst && (w_cmd == CMD_MRS) && w_mrs_ok;

    // Violation flags; each flagged command is dropped by the *_ok terms above
    always_comb begin
        w_err_set    = '0;
        w_err_set[0] = ((w_cmd == CMD_ACT) || w_rw) && !w_ready;
        w_err_set[1] = (w_cmd == CMD_ACT) && w_ready && w_bank_open;
        w_err_set[2] = w_rw && w_ready && !w_bank_open;
        w_err_set[3] = w_rw && w_ready && w_bank_open && !w_age_ok;
        w_err_set[4] = ((w_cmd == CMD_WR) && w_ready && w_bank_open && w_age_ok && r_pv[0])
                       || ((w_cmd == CMD_REF) && w_ready && (|r_open));
        w_err_set[5] = (w_cmd == CMD_MRS) && !w_mrs_ok;
    end

    assign w_idx     = {ba, r_row[ba], addr[COL_BITS-1:0]};
    assign w_rd_word = r_mem[w_idx];
    assign w_rd_dat  = {(udqm ? 8'h00 : w_rd_word[15:8]), (ldqm ? 8'h00 : w_rd_word[7:0])};
    assign w_slot    = 2'(r_cl - 3'd1);
    assign w_unused  = ^{addr, ROW_BITS[0]};

    // Init FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT_PRE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Init FSM next state and init_done
    always_comb begin
        w_state_nxt = r_state;
        w_init_done = 1'b0;
        case (r_state)
            S_INIT_PRE: if (w_cmd == CMD_PRE) w_state_nxt = S_INIT_REF;
            S_INIT_REF: if ((w_cmd == CMD_REF) && r_init_ref) w_state_nxt = S_INIT_MRS;
            S_INIT_MRS: if (w_mrs_acc) w_state_nxt = S_READY;
            default: begin
                w_state_nxt = S_READY;
                w_init_done = 1'b1;
            end
        endcase
    end

    // First of the two init refreshes, mode register and sticky status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_ref <= 1'b0;
            r_cl       <= 3'd2;
            r_err      <= '0;
            r_ref_cnt  <= '0;
        end else begin
            if ((r_state == S_INIT_REF) && (w_cmd == CMD_REF)) r_init_ref <= 1'b1;
            if (w_mrs_acc) r_cl <= addr[6:4];
            r_err <= r_err | w_err_set;
            if (w_ref_ok && (r_ref_cnt != 16'hFFFF)) r_ref_cnt <= r_ref_cnt + 16'd1;
        end
    end

    // Per-bank open flag, open row and ACTIVE age
    always_ff @(posedge clk) begin
        if (rst) begin
            r_open <= '0;
            for (int b = 0; b < 4; b++) begin
                r_row[b] <= '0;
                r_age[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_act_ok && (ba == 2'(b))) begin
                    r_age[b] <= '0;
                end else if (r_age[b] != AGE_MAX) begin
                    r_age[b] <= r_age[b] + 1'b1;
                end
            end
            if (w_act_ok) begin
                r_open[ba] <= 1'b1;
                r_row[ba]  <= addr[ROW_BITS-1:0];
            end
            if (w_rw_ok && addr[10]) r_open[ba] <= 1'b0;
            if (!rst && (w_cmd == CMD_PRE)) begin
                if (addr[10]) r_open <= '0;
                else          r_open[ba] <= 1'b0;
            end
        end
    end

    // Byte-masked write into the addressed word
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            if (!ldqm) r_mem[w_idx][7:0]  <= dq_in[7:0];
            if (!udqm) r_mem[w_idx][15:8] <= dq_in[15:8];
        end
    end

    // Read-latency shift register; reset cancels anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
            for (int i = 0; i < 3; i++) r_pd[i] <= '0;
        end else begin
            r_pv[0] <= r_pv[1];
            r_pv[1] <= r_pv[2];
            r_pv[2] <= 1'b0;
            r_pd[0] <= r_pd[1];
            r_pd[1] <= r_pd[2];
            r_pd[2] <= '0;
            if (w_rd_ok) begin
                r_pv[w_slot] <= 1'b1;
                r_pd[w_slot] <= w_rd_dat;
            end
        end
    end

    assign dq_oe     = r_pv[0];
    assign dq_out    = r_pv[0] ? r_pd[0] : 16'h0000;
    assign init_done = w_init_done;
    assign err       = r_err;
    assign ref_cnt   = r_ref_cnt;

endmodule

// File: tb/tb_sdram_responder.sv
// Purpose : directed bench for sdram_responder with a read-data scoreboard.
// Latency : expected reads are queued with their due cycle and checked by a negedge monitor.
// Backpr. : none; commands are driven one per cycle between positive edges.
module tb_sdram_responder;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke, cs_n, ras_n, cas_n, we_n, ldqm, udqm;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        init_done;
    logic [5:0]  err;
    logic [15:0] ref_cnt;

    sdram_responder #(.ROW_BITS(4), .COL_BITS(4), .TRCD(1)) dut (
        .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ldqm(ldqm), .udqm(udqm), .ba(ba), .addr(addr), .dq_in(dq_in),
        .dq_out(dq_out), .dq_oe(dq_oe), .init_done(init_done), .err(err), .ref_cnt(ref_cnt)
    );

    always #5 clk = ~clk;

    int pcnt = 0;
    always @(posedge clk) pcnt++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          due;
        logic [15:0] dat;
    } exp_t;
    exp_t sb[$];

    int          cl_m = 2;
    logic [15:0] mem_m [0:1023];
    logic [5:0]  exp_err = '0;
    logic        mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: dq_oe must pulse exactly on each queued due cycle with the queued word
    always @(negedge clk) begin
        mon_exp = (sb.size() > 0) && (sb[0].due == pcnt);
        tests++;
        assert (dq_oe === mon_exp) else begin
            fails++;
            $error("FAIL dq_oe@%0d: observed %b expected %b", pcnt, dq_oe, mon_exp);
        end
        if (mon_exp && dq_oe) begin
            tests++;
            assert (dq_out === sb[0].dat) else begin
                fails++;
                $error("FAIL rd_data@%0d: observed %h expected %h", pcnt, dq_out, sb[0].dat);
            end
        end else if (!dq_oe) begin
            tests++;
            assert (dq_out === 16'h0000) else begin
                fails++;
                $error("FAIL dq_out_idle@%0d: observed %h expected 0000", pcnt, dq_out);
            end
        end
        if (mon_exp) void'(sb.pop_front());
    end

    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [15:0] d, input logic lm, input logic um);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba = b; addr = a; dq_in = d; ldqm = lm; udqm = um;
        @(posedge clk); #1;
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        ldqm = 1'b0; udqm = 1'b0;
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] row, input logic [3:0] col, input logic ap,
                      input logic [15:0] d, input logic lm, input logic um, input logic legal);
        logic [9:0] idx;
        idx = {b, row, col};
        if (legal) begin
            if (!lm) mem_m[idx][7:0]  = d[7:0];
            if (!um) mem_m[idx][15:8] = d[15:8];
        end
        issue(C_WR, b, {2'b00, ap, 6'b0, col}, d, lm, um);
    endtask

    task automatic rd(input logic [1:0] b, input logic [3:0] row, input logic [3:0] col, input logic ap,
                      input logic lm, input logic um, input logic legal);
        logic [9:0]  idx;
        logic [15:0] w;
        exp_t        e;
        idx = {b, row, col};
        w = mem_m[idx];
        if (legal) begin
            e.due = pcnt + cl_m;
            e.dat = {(um ? 8'h00 : w[15:8]), (lm ? 8'h00 : w[7:0])};
            sb.push_back(e);
        end
        issue(C_RD, b, {2'b00, ap, 6'b0, col}, 16'h0, lm, um);
    endtask

    task automatic init_seq();
        issue(C_PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 1'b0);
        chk("init_pre_not_done", 32'(init_done), 32'd0);
        issue(C_REF, 2'd0, 13'h0000, 16'h0, 1'b0, 1'b0);
        issue(C_REF, 2'd0, 13'h0000, 16'h0, 1'b0, 1'b0);
        chk("init_ref_not_done", 32'(init_done), 32'd0);
        issue(C_MRS, 2'd0, 13'h0228, 16'h0, 1'b0, 1'b0);
        cl_m = 2;
        chk("init_done_after_mrs", 32'(init_done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
        ldqm = 1'b0; udqm = 1'b0; ba = '0; addr = '0; dq_in = '0;
        nop(3);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ref_cnt", 32'(ref_cnt), 32'd0);
        chk("rst_dq_oe", 32'(dq_oe), 32'd0);
        chk("rst_dq_out", 32'(dq_out), 32'd0);
        rst = 1'b0;
        nop(1);

        init_seq();
        chk("init_ref_cnt", 32'(ref_cnt), 32'd2);
        chk("init_err", 32'(err), 32'd0);

        // Basic write/read at CL=2, then byte-masked write and read masks
        issue(C_ACT, 2'd1, 13'd3, 16'h0, 1'b0, 1'b0);
        nop(1);
        wr(2'd1, 4'd3, 4'd5, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(3);
        wr(2'd1, 4'd3, 4'd5, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1);
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(3);
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        nop(3);

        // Auto-precharge write, then READ to the now closed bank is flagged
        wr(2'd1, 4'd3, 4'd6, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b1);
        chk("ap_write_err", 32'(err), 32'(exp_err));
        rd(2'd1, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_err[2] = 1'b1;
        chk("rd_closed_err", 32'(err), 32'(exp_err));
        nop(3);
        issue(C_ACT, 2'd1, 13'd3, 16'h0, 1'b0, 1'b0);
        nop(1);
        rd(2'd1, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(3);

        // ACTIVE to an open bank is flagged and leaves the open row alone
        issue(C_ACT, 2'd1, 13'd7, 16'h0, 1'b0, 1'b0);
        exp_err[1] = 1'b1;
        chk("act_open_err", 32'(err), 32'(exp_err));
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(3);

        // WRITE while read data is on the bus is flagged and dropped
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(1);
        wr(2'd1, 4'd3, 4'd5, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        exp_err[4] = 1'b1;
        chk("wr_during_oe_err", 32'(err), 32'(exp_err));
        nop(2);
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(3);

        // Refresh with a bank open is not counted; after precharge-all it is
        issue(C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        chk("ref_bank_open_cnt", 32'(ref_cnt), 32'd2);
        chk("ref_bank_open_err", 32'(err), 32'(exp_err));
        issue(C_PRE, 2'd0, 13'h0400, 16'h0, 1'b0, 1'b0);
        issue(C_REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        chk("ref_cnt_3", 32'(ref_cnt), 32'd3);

        // Invalid mode (CL=1) is rejected and CL stays 2
        issue(C_MRS, 2'd0, 13'h0010, 16'h0, 1'b0, 1'b0);
        exp_err[5] = 1'b1;
        chk("mrs_invalid_err", 32'(err), 32'(exp_err));
        issue(C_ACT, 2'd1, 13'd3, 16'h0, 1'b0, 1'b0);
        nop(1);
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(3);

        // CL=3 with back-to-back reads
        issue(C_MRS, 2'd0, 13'h0030, 16'h0, 1'b0, 1'b0);
        cl_m = 3;
        chk("mrs_cl3_err", 32'(err), 32'(exp_err));
        chk("mrs_cl3_ready", 32'(init_done), 32'd1);
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(5);

        // Reset one cycle after a READ cancels its data
        issue(C_RD, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        nop(2);
        rst = 1'b0;
        cl_m = 2;
        exp_err = '0;
        chk("rerst_init_done", 32'(init_done), 32'd0);
        chk("rerst_err", 32'(err), 32'd0);
        chk("rerst_ref_cnt", 32'(ref_cnt), 32'd0);
        nop(3);

        // ACTIVE before init is flagged
        issue(C_ACT, 2'd1, 13'd3, 16'h0, 1'b0, 1'b0);
        exp_err[0] = 1'b1;
        chk("act_pre_init_err", 32'(err), 32'(exp_err));

        // Re-init; memory survives reset
        init_seq();
        chk("reinit_err", 32'(err), 32'(exp_err));
        chk("reinit_ref_cnt", 32'(ref_cnt), 32'd2);
        issue(C_ACT, 2'd1, 13'd3, 16'h0, 1'b0, 1'b0);
        nop(1);
        rd(2'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        nop(4);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
